// File: rtl/ad7674_pkg.sv
// rtl/ad7674_pkg.sv - shared widths, word slices and output-state type for the AD7674 averager
package ad7674_pkg;

  // One AD7674 conversion channel and the packed two-channel capture word.
  localparam int CH_W   = 18;
  localparam int WORD_W = 36;

  // Channel positions inside the capture word: {ch0, ch1}.
  localparam int CH0_HI = 35;
  localparam int CH0_LO = 18;
  localparam int CH1_HI = 17;
  localparam int CH1_LO = 0;

  // Largest supported decimation exponent; also sizes the sample counter.
  localparam int MAX_LOG2_N = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/ad7674_avg_channel.sv
// rtl/ad7674_avg_channel.sv - one channel's signed block accumulator and floor-divided mean
module ad7674_avg_channel
  import ad7674_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Clear,
  input  logic            Sample,
  input  logic            Last,
  input  logic [CH_W-1:0] Din,
  output logic [CH_W-1:0] Mean
);

  // 2^LOG2_N samples of CH_W bits always fit in CH_W+LOG2_N bits.
  localparam int ACC_W = CH_W + LOG2_N;

  logic signed [CH_W-1:0]  din_s;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign din_s = Din;

  // The block total includes the sample being taken this cycle, so the mean
  // is ready in the same cycle the last sample arrives.
  assign sum  = acc + ACC_W'(din_s);
  assign Mean = CH_W'(sum >>> LOG2_N);

  // Accumulate on each sample; restart from zero after the block's last sample.
  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      acc <= '0;
    end else if (Sample) begin
      acc <= Last ? '0 : sum;
    end
  end

endmodule

// File: rtl/ad7674_averager.sv
// rtl/ad7674_averager.sv - decimating block averager for the AD7674 capture stream
module ad7674_averager
  import ad7674_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Sync,
  input  logic              Enable,
  input  logic [WORD_W-1:0] DataIn,
  output logic [WORD_W-1:0] DataOut,
  output logic              Valid,
  input  logic              Ready,
  output logic              Overrun,
  input  logic              ClearOverrun
);

  localparam logic [MAX_LOG2_N-1:0] LAST_CNT = MAX_LOG2_N'((1 << LOG2_N) - 1);

  logic [1:0]            tSync;
  logic                  Strobe;
  logic [MAX_LOG2_N-1:0] count;
  logic                  sample;
  logic                  last;
  logic                  result;
  logic [CH_W-1:0]       mean0;
  logic [CH_W-1:0]       mean1;
  out_state_t            state;
  out_state_t            state_next;
  logic                  load;
  logic                  overrun_set;

  // Detect the Sync rising edge; Strobe lags it by one cycle so the capture
  // stage has already updated DataIn when the sample is taken.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tSync  <= 2'b00;
      Strobe <= 1'b0;
    end else begin
      tSync  <= {tSync[0], Sync};
      Strobe <= (tSync == 2'b01);
    end
  end

  assign sample = Strobe & Enable;
  assign last   = (count == LAST_CNT);
  assign result = sample & last;

  // Samples taken in the current block; held at zero while disabled.
  always_ff @(posedge Clk) begin
    if (Reset || !Enable) begin
      count <= '0;
    end else if (sample) begin
      count <= last ? '0 : count + MAX_LOG2_N'(1);
    end
  end

  ad7674_avg_channel #(.LOG2_N(LOG2_N)) u_ch0 (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (!Enable),
    .Sample (sample),
    .Last   (last),
    .Din    (DataIn[CH0_HI:CH0_LO]),
    .Mean   (mean0)
  );

  ad7674_avg_channel #(.LOG2_N(LOG2_N)) u_ch1 (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (!Enable),
    .Sample (sample),
    .Last   (last),
    .Din    (DataIn[CH1_HI:CH1_LO]),
    .Mean   (mean1)
  );

  // Output holding register state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Handshake: load when empty or being drained, drop and flag when stalled.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    overrun_set = 1'b0;
    Valid       = (state == OUT_FULL);
    case (state)
      OUT_EMPTY: begin
        if (result) begin
          load       = 1'b1;
          state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (Ready) begin
          if (result) begin
            load = 1'b1;
          end else begin
            state_next = OUT_EMPTY;
          end
        end else if (result) begin
          overrun_set = 1'b1;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // Result register and sticky overrun flag; a new overrun beats a clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DataOut <= '0;
      Overrun <= 1'b0;
    end else begin
      if (load) begin
        DataOut <= {mean0, mean1};
      end
      Overrun <= overrun_set | (Overrun & ~ClearOverrun);
    end
  end

endmodule

// File: tb/tb_ad7674_averager.sv
// tb/tb_ad7674_averager.sv - directed vectors and corner sequences for ad7674_averager
module tb_ad7674_averager;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Sync;
  logic        Enable;
  logic        Ready;
  logic        ClearOverrun;
  logic [35:0] DataIn;
  logic [35:0] DataOut2, DataOut4;
  logic        Valid2, Valid4;
  logic        Overrun2, Overrun4;

  int tests  = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  ad7674_averager #(.LOG2_N(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Sync(Sync), .Enable(Enable), .DataIn(DataIn),
    .DataOut(DataOut2), .Valid(Valid2), .Ready(Ready), .Overrun(Overrun2),
    .ClearOverrun(ClearOverrun)
  );

  ad7674_averager #(.LOG2_N(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Sync(Sync), .Enable(Enable), .DataIn(DataIn),
    .DataOut(DataOut4), .Valid(Valid4), .Ready(Ready), .Overrun(Overrun4),
    .ClearOverrun(ClearOverrun)
  );

  typedef struct {
    logic [3:0][17:0] c0;
    logic [3:0][17:0] c1;
    logic [17:0]      m0;
    logic [17:0]      m1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Raise Sync for one edge (E0) with the sample on DataIn.
  task automatic start_pulse(input logic [17:0] d0, input logic [17:0] d1);
    DataIn = {d0, d1};
    Sync   = 1'b1;
    tick();
    Sync   = 1'b0;
  endtask

  // One 8-cycle Sync period.
  task automatic full_pulse(input logic [17:0] d0, input logic [17:0] d1);
    start_pulse(d0, d1);
    repeat (7) tick();
  endtask

  task automatic block4(input logic [17:0] d0, input logic [17:0] d1);
    repeat (4) full_pulse(d0, d1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Sync = 1'b0; Enable = 1'b1; Ready = 1'b1; ClearOverrun = 1'b0;
    DataIn = '0;

    vecs[0] = '{c0: {4{18'd100}}, c1: {4{-18'sd100}}, m0: 18'd100, m1: -18'sd100};
    vecs[1] = '{c0: {18'd1, 18'd2, 18'd2, 18'd2},
                c1: {-18'sd1, -18'sd2, -18'sd2, -18'sd2}, m0: 18'd1, m1: -18'sd2};
    vecs[2] = '{c0: {18'd0, 18'd0, 18'd0, 18'd3},
                c1: {-18'sd1, 18'd0, 18'd0, 18'd0}, m0: 18'd0, m1: -18'sd1};
    vecs[3] = '{c0: {4{18'h1FFFF}}, c1: {4{18'h20000}}, m0: 18'h1FFFF, m1: 18'h20000};
    vecs[4] = '{c0: {18'd5, 18'd6, 18'd7, 18'd8},
                c1: {-18'sd5, 18'd6, -18'sd7, 18'd8}, m0: 18'd6, m1: 18'd0};

    // Reset state
    repeat (2) tick();
    check("reset dataout", DataOut2, 36'd0);
    check("reset valid", Valid2, 36'd0);
    check("reset overrun", Overrun2, 36'd0);
    check("reset valid4", Valid4, 36'd0);
    Reset = 1'b0;

    // Table-driven blocks, LOG2_N=2, Ready=1
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 3; j++) full_pulse(vecs[v].c0[j], vecs[v].c1[j]);
      start_pulse(vecs[v].c0[3], vecs[v].c1[3]);
      tick();
      check($sformatf("vec%0d valid before E2", v), Valid2, 36'd0);
      tick();
      check($sformatf("vec%0d valid at E2", v), Valid2, 36'd1);
      check($sformatf("vec%0d dataout", v), DataOut2, {vecs[v].m0, vecs[v].m1});
      tick();
      check($sformatf("vec%0d valid after accept", v), Valid2, 36'd0);
      repeat (4) tick();
    end

    // Full scale, LOG2_N=4: no wrap in either direction
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) begin
        start_pulse(b == 0 ? 18'h1FFFF : 18'h20000, b == 0 ? 18'h00000 : 18'h3FFFF);
        repeat (2) tick();
        if (i == 14) check($sformatf("fs%0d valid early", b), Valid4, 36'd0);
        if (i == 15) begin
          check($sformatf("fs%0d valid", b), Valid4, 36'd1);
          check($sformatf("fs%0d dataout", b), DataOut4,
                b == 0 ? {18'h1FFFF, 18'h00000} : {18'h20000, 18'h3FFFF});
        end
        repeat (5) tick();
      end
    end
    check("fs overrun", Overrun4, 36'd0);

    // Overrun: hold, drop, clear, accept-with-result, set beats clear
    do_reset();
    Ready = 1'b0;
    block4(18'd10, 18'd20);
    check("ovr first valid", Valid2, 36'd1);
    check("ovr first data", DataOut2, {18'd10, 18'd20});
    check("ovr first flag", Overrun2, 36'd0);
    block4(18'd30, 18'd40);
    check("ovr held valid", Valid2, 36'd1);
    check("ovr held data", DataOut2, {18'd10, 18'd20});
    check("ovr set", Overrun2, 36'd1);
    ClearOverrun = 1'b1;
    tick();
    ClearOverrun = 1'b0;
    check("ovr cleared", Overrun2, 36'd0);
    repeat (3) full_pulse(18'd50, 18'd60);
    start_pulse(18'd50, 18'd60);
    tick();
    Ready = 1'b1;
    tick();
    check("swap valid", Valid2, 36'd1);
    check("swap data", DataOut2, {18'd50, 18'd60});
    check("swap no overrun", Overrun2, 36'd0);
    tick();
    check("swap drained", Valid2, 36'd0);
    Ready = 1'b0;
    repeat (4) tick();
    block4(18'd1, 18'd1);
    repeat (3) full_pulse(18'd2, 18'd2);
    start_pulse(18'd2, 18'd2);
    tick();
    ClearOverrun = 1'b1;
    tick();
    ClearOverrun = 1'b0;
    check("set beats clear", Overrun2, 36'd1);
    check("set beats clear data", DataOut2, {18'd1, 18'd1});
    repeat (5) tick();

    // Enable drop discards partial block
    do_reset();
    Ready = 1'b1;
    full_pulse(18'd1000, -18'sd1000);
    full_pulse(18'd1000, -18'sd1000);
    Enable = 1'b0;
    repeat (3) tick();
    Enable = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      start_pulse(18'd8, -18'sd8);
      repeat (2) tick();
      check($sformatf("en fresh%0d no valid", j), Valid2, 36'd0);
      repeat (5) tick();
    end
    start_pulse(18'd8, -18'sd8);
    repeat (2) tick();
    check("en valid", Valid2, 36'd1);
    check("en data", DataOut2, {18'd8, -18'sd8});
    repeat (5) tick();

    // Reset mid-block with Valid and Overrun set
    Ready = 1'b0;
    block4(18'd7, 18'd7);
    block4(18'd9, 18'd9);
    check("pre-reset overrun", Overrun2, 36'd1);
    full_pulse(18'd100, 18'd100);
    full_pulse(18'd100, 18'd100);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst mid valid", Valid2, 36'd0);
    check("rst mid data", DataOut2, 36'd0);
    check("rst mid overrun", Overrun2, 36'd0);

    // Sync held high for 10 cycles yields one sample
    Ready = 1'b1;
    DataIn = {18'd4, -18'sd4};
    Sync = 1'b1;
    repeat (10) tick();
    Sync = 1'b0;
    repeat (4) tick();
    for (int j = 0; j < 2; j++) begin
      start_pulse(18'd8, -18'sd8);
      repeat (2) tick();
      check($sformatf("held sync%0d no valid", j), Valid2, 36'd0);
      repeat (5) tick();
    end
    start_pulse(18'd8, -18'sd8);
    repeat (2) tick();
    check("held sync valid", Valid2, 36'd1);
    check("held sync data", DataOut2, {18'd7, -18'sd7});
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
